// File: rtl/countdown_sequencer.sv
// countdown_sequencer: loadable down-counter with start/busy/done handshake.
// Ports: clk, reset (async, active-high), start, load_val[x-1:0] (0 selects n),
//   en (step enable), abort; outputs busy (RUN), step (RUN && en, combinational),
//   count[x-1:0] (steps remaining), done (one-cycle pulse in DONE).
// Latency: start to done is L+1 cycles with en held high; each en=0 RUN cycle adds one.
// Optional feature: define COUNTDOWN_AUTORELOAD_EN so that DONE re-enters RUN
//   with count reloaded from the captured step count (periodic done pulses).
module countdown_sequencer #(
  parameter int x = 4,
  parameter int n = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [x-1:0] load_val,
  input  logic         en,
  input  logic         abort,
  output logic         busy,
  output logic         step,
  output logic [x-1:0] count,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [x-1:0] DEF_LOAD = x'(n);

  state_t       state_q, state_d;
  logic [x-1:0] count_q, count_d;
  logic [x-1:0] reload_q, reload_d;
  logic [x-1:0] load_sel;

  // A zero load value means "use the default step count".
  assign load_sel = (load_val == '0) ? DEF_LOAD : load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    unique case (state_q)
      IDLE: begin
        // abort beats start
        if (start && !abort) begin
          count_d  = load_sel;
          reload_d = load_sel;
          state_d  = RUN;
        end
      end
      RUN: begin
        // abort has priority over both stepping and completion
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (en) begin
          // leave RUN on the 1->0 step so count never wraps
          if (count_q == x'(1)) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q - x'(1);
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
`ifdef COUNTDOWN_AUTORELOAD_EN
          count_d = reload_q;
          state_d = RUN;
`else
          state_d = IDLE;
`endif
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy  = (state_q == RUN);
  assign step  = (state_q == RUN) && en;
  assign done  = (state_q == DONE);
  assign count = count_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Testbench for countdown_sequencer (x=4, n=3). Each scenario queues per-cycle
// stimulus together with the outputs the timing rules predict for that cycle,
// then replays the stimulus and pops/compares one expected entry per cycle.
module tb_countdown_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] load_val;
  logic       en;
  logic       abort;
  logic       busy;
  logic       step;
  logic [3:0] count;
  logic       done;

  int total;
  int bad;

  // stimulus entry {start, abort, en}; expected entry {count, busy, done, step}
  logic [2:0] stim_q[$];
  logic [6:0] exp_q[$];

  countdown_sequencer #(.x(4), .n(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load_val (load_val),
    .en       (en),
    .abort    (abort),
    .busy     (busy),
    .step     (step),
    .count    (count),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ev(input logic [3:0] c, input logic b, input logic d, input logic s);
    return {c, b, d, s};
  endfunction

  task automatic push(input logic s, input logic a, input logic e, input logic [6:0] ex);
    stim_q.push_back({s, a, e});
    exp_q.push_back(ex);
  endtask

  // One cycle: drive inputs just after a rising edge, then wait for the falling edge to sample.
  task automatic apply(input logic [2:0] sv);
    @(posedge clk);
    #1;
    start = sv[2];
    abort = sv[1];
    en    = sv[0];
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [6:0] obs;
    logic [6:0] ex;
    logic [2:0] sv;
    int i;
    load_val = 4'd5;
    push(1, 0, 1, ev(0, 0, 0, 0));
    push(0, 0, 1, ev(5, 1, 0, 1));
    push(0, 0, 1, ev(4, 1, 0, 1));
    push(0, 0, 1, ev(3, 1, 0, 1));
    i = 0;
    while (stim_q.size() > 0) begin
      sv = stim_q.pop_front();
      apply(sv);
      ex = exp_q.pop_front();
      obs = {count, busy, done, step};
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL reset_pre cyc%0d got=%h want=%h", i, obs, ex);
      end
      i++;
    end
    // asynchronous reset mid-RUN, checked before any clock edge
    reset = 1'b1;
    #1;
    obs = {count, busy, done, step};
    total++;
    if (obs !== 7'h00) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", obs, 7'h00);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) push(0, 0, 1, ev(0, 0, 0, 0));
    i = 0;
    while (stim_q.size() > 0) begin
      sv = stim_q.pop_front();
      apply(sv);
      ex = exp_q.pop_front();
      obs = {count, busy, done, step};
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL reset_post cyc%0d got=%h want=%h", i, obs, ex);
      end
      i++;
    end
  endtask

  task automatic test_basic;
    logic [6:0] obs;
    logic [6:0] ex;
    logic [2:0] sv;
    int i;
    int n_step;
    int n_done;
    load_val = 4'd5;
    push(1, 0, 1, ev(0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) push(0, 0, 1, ev(4'(6 - k), 1, 0, 1));
    push(0, 1, 0, ev(0, 0, 1, 0));
    push(0, 0, 0, ev(0, 0, 0, 0));
    i = 0;
    n_step = 0;
    n_done = 0;
    while (stim_q.size() > 0) begin
      sv = stim_q.pop_front();
      apply(sv);
      ex = exp_q.pop_front();
      obs = {count, busy, done, step};
      if (step === 1'b1) n_step++;
      if (done === 1'b1) n_done++;
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL basic cyc%0d got=%h want=%h", i, obs, ex);
      end
      i++;
    end
    total++;
    if (n_step !== 5) begin
      bad++;
      $display("FAIL basic_step_count got=%0d want=5", n_step);
    end
    total++;
    if (n_done !== 1) begin
      bad++;
      $display("FAIL basic_done_count got=%0d want=1", n_done);
    end
  endtask

  task automatic test_default_load;
    logic [6:0] obs;
    logic [6:0] ex;
    logic [2:0] sv;
    int i;
    load_val = 4'd0;
    push(1, 0, 1, ev(0, 0, 0, 0));
    for (int k = 1; k <= 3; k++) push(0, 0, 1, ev(4'(4 - k), 1, 0, 1));
    push(0, 1, 0, ev(0, 0, 1, 0));
    push(0, 0, 0, ev(0, 0, 0, 0));
    i = 0;
    while (stim_q.size() > 0) begin
      sv = stim_q.pop_front();
      apply(sv);
      ex = exp_q.pop_front();
      obs = {count, busy, done, step};
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL default_load cyc%0d got=%h want=%h", i, obs, ex);
      end
      i++;
    end
  endtask

  task automatic test_stall;
    logic [6:0] obs;
    logic [6:0] ex;
    logic [2:0] sv;
    int i;
    load_val = 4'd2;
    push(1, 0, 0, ev(0, 0, 0, 0));
    push(0, 0, 0, ev(2, 1, 0, 0));
    push(1, 0, 0, ev(2, 1, 0, 0));   // start during RUN must be ignored
    push(0, 0, 0, ev(2, 1, 0, 0));
    push(0, 0, 1, ev(2, 1, 0, 1));
    push(0, 0, 1, ev(1, 1, 0, 1));
    push(0, 1, 0, ev(0, 0, 1, 0));
    push(0, 0, 0, ev(0, 0, 0, 0));
    i = 0;
    while (stim_q.size() > 0) begin
      sv = stim_q.pop_front();
      apply(sv);
      ex = exp_q.pop_front();
      obs = {count, busy, done, step};
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL stall cyc%0d got=%h want=%h", i, obs, ex);
      end
      i++;
    end
  endtask

  task automatic test_abort;
    logic [6:0] obs;
    logic [6:0] ex;
    logic [2:0] sv;
    int i;
    load_val = 4'd3;
    push(1, 0, 1, ev(0, 0, 0, 0));
    push(0, 0, 1, ev(3, 1, 0, 1));
    push(0, 0, 1, ev(2, 1, 0, 1));
    push(0, 1, 1, ev(1, 1, 0, 1));   // abort together with the final step
    push(0, 0, 1, ev(0, 0, 0, 0));
    push(0, 0, 1, ev(0, 0, 0, 0));
    push(1, 1, 1, ev(0, 0, 0, 0));   // start with abort in IDLE
    push(0, 0, 1, ev(0, 0, 0, 0));
    push(0, 0, 1, ev(0, 0, 0, 0));
    i = 0;
    while (stim_q.size() > 0) begin
      sv = stim_q.pop_front();
      apply(sv);
      ex = exp_q.pop_front();
      obs = {count, busy, done, step};
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL abort cyc%0d got=%h want=%h", i, obs, ex);
      end
      i++;
    end
  endtask

  task automatic test_autoreload;
    logic [6:0] obs;
    logic [6:0] ex;
    logic [2:0] sv;
    int i;
    load_val = 4'd2;
    push(1, 0, 1, ev(0, 0, 0, 0));
    push(0, 0, 1, ev(2, 1, 0, 1));
    push(0, 0, 1, ev(1, 1, 0, 1));
    push(0, 0, 1, ev(0, 0, 1, 0));
`ifdef COUNTDOWN_AUTORELOAD_EN
    push(0, 0, 1, ev(2, 1, 0, 1));
    push(0, 0, 1, ev(1, 1, 0, 1));
    push(0, 0, 1, ev(0, 0, 1, 0));
    push(0, 0, 1, ev(2, 1, 0, 1));
    push(0, 0, 1, ev(1, 1, 0, 1));
    push(0, 1, 1, ev(0, 0, 1, 0));   // abort in DONE stops the repetition
`else
    for (int k = 4; k <= 9; k++) push(0, (k == 9) ? 1'b1 : 1'b0, 1, ev(0, 0, 0, 0));
`endif
    push(0, 0, 1, ev(0, 0, 0, 0));
    push(0, 0, 1, ev(0, 0, 0, 0));
    i = 0;
    while (stim_q.size() > 0) begin
      sv = stim_q.pop_front();
      apply(sv);
      ex = exp_q.pop_front();
      obs = {count, busy, done, step};
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL autoreload cyc%0d got=%h want=%h", i, obs, ex);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] obs;
    logic [6:0] ex;
    logic [2:0] sv;
    int i;
    load_val = 4'd2;
    push(1, 0, 1, ev(0, 0, 0, 0));
    push(0, 0, 1, ev(2, 1, 0, 1));
    push(0, 0, 1, ev(1, 1, 0, 1));
    push(0, 1, 1, ev(0, 0, 1, 0));
    push(1, 0, 1, ev(0, 0, 0, 0));   // start in the IDLE cycle right after DONE
    push(0, 0, 1, ev(2, 1, 0, 1));
    push(0, 0, 1, ev(1, 1, 0, 1));
    push(0, 1, 0, ev(0, 0, 1, 0));
    push(0, 0, 0, ev(0, 0, 0, 0));
    i = 0;
    while (stim_q.size() > 0) begin
      sv = stim_q.pop_front();
      apply(sv);
      ex = exp_q.pop_front();
      obs = {count, busy, done, step};
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL back_to_back cyc%0d got=%h want=%h", i, obs, ex);
      end
      i++;
    end
  endtask

  initial begin
    logic [6:0] obs;
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    en       = 1'b0;
    load_val = 4'd0;
    #2;
    obs = {count, busy, done, step};
    total++;
    if (obs !== 7'h00) begin
      bad++;
      $display("FAIL reset_initial got=%h want=%h", obs, 7'h00);
    end
    #20;
    reset = 1'b0;
    test_reset();
    test_basic();
    test_default_load();
    test_stall();
    test_abort();
    test_autoreload();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_sequencer.md
# countdown_sequencer

Loadable down-counter with a start/busy/done handshake. It is the counting-down counterpart of the mod-N up-counter. It sequences a fixed number of enabled steps, such as the per-bit iterations of the sequential signed multiplier datapath, and reports completion with a single-cycle `done` pulse. One instance sits in each multiplier control path, between the top-level start request and the shift/add datapath.

## Interface
Parameters:
- `x`, 4: counter width in bits.
- `n`, 3: default step count, used when `load_val` is 0. Legal range is 1 ≤ n ≤ 2^x−1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sequence; sampled only in IDLE.
- `load_val`  in  x  number of steps; 0 means use `n`.
- `en`  in  1  step enable; one decrement per enabled cycle in RUN.
- `abort`  in  1  cancel the sequence; no `done` is produced.
- `busy`  out  1  high in RUN.
- `step`  out  1  combinational; equals RUN && `en`. The datapath uses it as its advance strobe.
- `count`  out  x  steps remaining.
- `done`  out  1  one-cycle pulse; high in the DONE state.

## Operation
- States are IDLE, RUN and DONE. Each is decoded from a registered state variable.
- Reset (asynchronous, at any time including mid-sequence):
  - state goes to IDLE;
  - `count`, `busy`, `done` and `step` are all 0;
  - the reload register is 0.
- IDLE:
  - `start`=1 and `abort`=0: load L into `count` and into the reload register, then go to RUN. L = `load_val`, or `n` if `load_val`=0.
  - `start` with `abort`: ignored; abort wins.
  - Otherwise `count` holds its value.
- RUN:
  - `abort`=1: go to IDLE with `count`←0. Abort has priority over `en` and over completion.
  - Else if `en`=1 and `count`=1: `count`←0, go to DONE.
  - Else if `en`=1: `count`←`count`−1.
  - `en`=0: hold.
  - `start` is ignored.
- DONE: lasts one cycle, with `done`=1 and `busy`=0. The next state depends on the configuration (see below); `abort`=1 always goes to IDLE.
- Arithmetic: unsigned, x bits. `count` never wraps below 0, because RUN is always left at 1→0.

## Timing
- `start` sampled high at edge t: `busy`=1 with `count`=L from t+1.
- With `en` held high:
  - `count` reads L, L−1, …, 1 over cycles t+1 … t+L;
  - `done`=1 in cycle t+L+1 only;
  - total latency from start to done is L+1 cycles.
- Each `en`=0 cycle in RUN delays `done` by exactly one cycle.
- `step` asserts in the same cycle as `en` whenever `busy`=1, so it is asserted exactly L times per completed sequence.
- Back-to-back use: a `start` in the cycle after DONE, which is IDLE, is accepted. The minimum period between sequences is therefore L+2 cycles.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined:
  - DONE with `abort`=0 goes to RUN, with `count` reloaded from the reload register.
  - This gives periodic `done` pulses every L+1 cycles while `en` is held high.
  - `abort` (in RUN or DONE) returns the block to IDLE; a later `start` is required to begin again.
- Not defined:
  - DONE always goes to IDLE;
  - the reload register still exists but is used only as a capture of L.

## Test plan
- Reset check: assert `reset` mid-RUN with `count`=3 (x=4, n=3). Required: `count`=0, `busy`=0 and `done`=0 immediately, without waiting for a clock edge. The block stays in IDLE after release.
- Basic sequence: `load_val`=5, one-cycle `start`, `en`=1. Required:
  - `busy` high for 5 cycles;
  - `count` reads 5, 4, 3, 2, 1;
  - `step` pulses 5 times;
  - `done` high for exactly one cycle, 6 cycles after the start edge;
  - then IDLE.
- Default load: `load_val`=0 with `start`. Required: `count`=3 (=n), and `done` 4 cycles after start.
- Stall: `load_val`=2, with `en` low for the first 3 RUN cycles. Required: `count` holds 2 during the stall, and `done` arrives at cycle 6 instead of 3. A `start` pulse during RUN has no effect.
- Abort priority:
  - In RUN with `count`=1, drive `abort`=1 and `en`=1 together. Required: next cycle IDLE, `count`=0, no `done` pulse.
  - Drive `start` and `abort` together in IDLE. Required: stays in IDLE.
- Autoreload (macro defined): `load_val`=2, `en`=1. Required: `done` at cycles 3, 6 and 9 after start, with `count` repeating 2, 1. `abort` in a DONE cycle stops the sequence. Without the macro, the same stimulus gives a single `done` at cycle 3 only.
